gate_vector_sequencer: RTL and testbench

- Synthesizable stimulus/check stage that wraps a combinational gate under test (e.g. the 2-input AND used in lab exercises).
- Drives every input vector of a WIDTH-bit gate in ascending order on `dut_inputs`.
- After a settle window, samples `dut_result` and compares it with the golden reduction function selected by `op`.
- Counts mismatches and reports pass/fail, so hardware runs need no simulator-only checker.

---
 rtl/gate_vector_sequencer.sv | 126 ++++++++++++
 tb/tb_gate_vector_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_sequencer.sv
// Stimulus/check stage: walks every WIDTH-bit vector into a gate under test and checks its output.
// Optional build macro GATE_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_vector_sequencer #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             dut_result,
    output logic [WIDTH-1:0] dut_inputs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail
);

    localparam logic [WIDTH-1:0] LastVec    = '1;
    localparam logic [3:0]       SettleLast = 4'(SETTLE - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e     state;
    logic [2:0] op_q;
    logic [3:0] wait_cnt;
    logic       golden;
    logic       mismatch;

    always_comb begin
        golden = 1'b0;
        unique case (op_q)
            3'd0: golden = &dut_inputs;
            3'd1: golden = |dut_inputs;
            3'd2: golden = ^dut_inputs;
            3'd3: golden = ~&dut_inputs;
            3'd4: golden = ~|dut_inputs;
            3'd5: golden = ~^dut_inputs;
            3'd6: golden = 1'b0;
            3'd7: golden = 1'b1;
            default: golden = 1'b0;
        endcase
        mismatch = (dut_result != golden);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            op_q       <= 3'd0;
            wait_cnt   <= 4'd0;
            dut_inputs <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        op_q       <= op;
                        err_count  <= '0;
                        fail_seen  <= 1'b0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        dut_inputs <= '0;
                        busy       <= 1'b1;
                        wait_cnt   <= 4'd0;
                        state      <= StSettle;
                    end
                end
                StSettle: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == SettleLast) begin
                        state <= StCheck;
                    end
                end
                StCheck: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_seen) begin
                            first_fail <= dut_inputs;
                            fail_seen  <= 1'b1;
                        end
                    end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        // First failure terminates: dut_inputs stays on the failing vector.
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end else if (dut_inputs == LastVec) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        dut_inputs <= dut_inputs + 1'b1;
                        wait_cnt   <= 4'd0;
                        state      <= StSettle;
                    end
`else
                    if (dut_inputs == LastVec) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Include this cycle's compare in the verdict.
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        dut_inputs <= dut_inputs + 1'b1;
                        wait_cnt   <= 4'd0;
                        state      <= StSettle;
                    end
`endif
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer (WIDTH=2, SETTLE=2): truth-table gate models against an
// arithmetic reference of the golden functions; honours GATE_SEQ_STOP_ON_FAIL_EN.
module tb_gate_vector_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic       dut_result;
    logic [1:0] dut_inputs;
    logic       busy, done, pass, fail_seen;
    logic [2:0] err_count;
    logic [1:0] first_fail;

    logic [3:0] tbl;   // gate-under-test truth table, indexed by vector
    int total = 0;
    int bad   = 0;

    gate_vector_sequencer #(.WIDTH(2), .SETTLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .dut_result (dut_result),
        .dut_inputs (dut_inputs),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_seen  (fail_seen),
        .first_fail (first_fail)
    );

    always #5 clk = ~clk;
    assign dut_result = tbl[dut_inputs];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit ref_golden(input int o, input int v);
        int ones;
        ones = (v % 2) + (v / 2);
        case (o)
            0: return ones == 2;
            1: return ones > 0;
            2: return (ones % 2) == 1;
            3: return ones != 2;
            4: return ones == 0;
            5: return (ones % 2) == 0;
            6: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // One run from a start pulse; restart_at>0 pulses start again mid-run.
    task automatic run(input string tag, input int op_v, input logic [3:0] tbl_v,
                       input int restart_at, input bit check_vec);
        int  errs, first, exp_cycle, exp_errs, exp_last, got_cycle;
        bit  stop_en;
        errs = 0;
        first = -1;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        stop_en = 1'b1;
`else
        stop_en = 1'b0;
`endif
        for (int v = 0; v < 4; v++) begin
            if (tbl_v[v] != ref_golden(op_v, v)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        if (stop_en && errs > 0) begin
            exp_cycle = (first + 1) * 3;
            exp_errs  = 1;
            exp_last  = first;
        end else begin
            exp_cycle = 12;
            exp_errs  = errs;
            exp_last  = 3;
        end

        tbl = tbl_v;
        @(negedge clk);
        op = 3'(op_v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'(~op_v);  // must be ignored mid-run
        got_cycle = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start = (k == restart_at);
            if (done) begin
                got_cycle = k;
                break;
            end
            if (check_vec) check({tag, " vec"}, int'(dut_inputs), k / 3);
        end
        start = 1'b0;
        check({tag, " done_cycle"}, got_cycle, exp_cycle);
        check({tag, " err_count"}, int'(err_count), exp_errs);
        check({tag, " pass"}, int'(pass), int'(errs == 0));
        check({tag, " fail_seen"}, int'(fail_seen), int'(errs > 0));
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " dut_inputs"}, int'(dut_inputs), exp_last);
        if (errs > 0) check({tag, " first_fail"}, int'(first_fail), first);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " dut_inputs"}, int'(dut_inputs), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " pass"}, int'(pass), 0);
        check({tag, " err_count"}, int'(err_count), 0);
        check({tag, " fail_seen"}, int'(fail_seen), 0);
        check({tag, " first_fail"}, int'(first_fail), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        tbl   = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start busy", int'(busy), 0);

        run("and_ok", 0, 4'b1000, 0, 1'b1);
        run("stuck0", 0, 4'b0000, 0, 1'b0);
        run("stuck1", 0, 4'b1111, 0, 1'b1);
        run("xor_vs_xnor", 5, 4'b0110, 0, 1'b0);
        run("restart_ignored", 0, 4'b1000, 5, 1'b1);

        // Reset mid-run at cycle 7 with errors already counted.
        tbl = 4'b1111;
        @(negedge clk);
        op = 3'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_reset busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        check("post_reset idle busy", int'(busy), 0);

        run("after_reset", 0, 4'b1000, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run("random", int'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 0, 1'b0);
        end
        for (int o = 0; o < 8; o++) begin
            logic [3:0] t;
            t = '0;
            for (int v = 0; v < 4; v++) t[v] = ref_golden(o, v);
            run("golden_ok", o, t, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
